// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad matrix scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_PRESS,
        ST_HELD,
        ST_DEB_REL
    } fsm_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_KEY,
        SCAN_MULTI
    } scan_res_t;

    // Bit position of the valid flag within the 5-bit key word.
    localparam int KEY_VALID_BIT = 4;

    // Key codes are {row[1:0], col[1:0]}; row 0 is the top row, column 0 the leftmost.
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_9    = 4'hA;
    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_0    = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_D    = 4'hF;

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        col_drive = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Scan-rate debounce state machine: qualifies presses and releases over
// consecutive identical whole-matrix scan results and owns the key word.
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_scan_stb,
    input  scan_res_t  i_scan_res,
    input  logic [3:0] i_scan_code,
    output logic [4:0] o_key_code,
    output logic       o_key_event
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

    fsm_state_t      r_state;
    fsm_state_t      w_state_nxt;
    logic [3:0]      r_cand;
    logic [3:0]      w_cand_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [4:0]      r_key_code;
    logic [4:0]      w_key_code_nxt;
    logic            r_key_event;

    // State, candidate, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= '0;
            r_key_code  <= 5'd0;
            r_key_event <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_code  <= w_key_code_nxt;
            // The event is registered alongside the code so both appear in the PRESS cycle.
            r_key_event <= (w_state_nxt == ST_PRESS);
        end
    end

    // Next-state logic; the key word is only rewritten on PRESS entry and release completion.
    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand;
        w_cnt_nxt      = r_cnt;
        w_key_code_nxt = r_key_code;
        unique case (r_state)
            ST_IDLE: begin
                if (i_scan_stb && i_scan_res == SCAN_KEY) begin
                    w_cand_nxt = i_scan_code;
                    w_cnt_nxt  = CNT_ONE;
                    if (DEBOUNCE_SCANS == 1) begin
                        w_state_nxt    = ST_PRESS;
                        w_key_code_nxt = {1'b1, i_scan_code};
                    end else begin
                        w_state_nxt = ST_DEB_PRESS;
                    end
                end
            end
            ST_DEB_PRESS: begin
                if (i_scan_stb) begin
                    if (i_scan_res == SCAN_KEY && i_scan_code == r_cand) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (w_cnt_nxt == CNT_DONE) begin
                            w_state_nxt    = ST_PRESS;
                            w_key_code_nxt = {1'b1, r_cand};
                        end
                    end else if (i_scan_res == SCAN_KEY) begin
                        w_cand_nxt = i_scan_code;
                        w_cnt_nxt  = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_PRESS: begin
                w_state_nxt = ST_HELD;
                w_cnt_nxt   = '0;
            end
            ST_HELD: begin
                if (i_scan_stb && i_scan_res == SCAN_NONE) begin
                    if (DEBOUNCE_SCANS == 1) begin
                        w_state_nxt    = ST_IDLE;
                        w_cnt_nxt      = '0;
                        w_key_code_nxt = 5'd0;
                    end else begin
                        w_state_nxt = ST_DEB_REL;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_DEB_REL: begin
                if (i_scan_stb) begin
                    if (i_scan_res == SCAN_NONE) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (w_cnt_nxt == CNT_DONE) begin
                            w_state_nxt    = ST_IDLE;
                            w_cnt_nxt      = '0;
                            w_key_code_nxt = 5'd0;
                        end
                    end else begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_key_code  = r_key_code;
    assign o_key_event = r_key_event;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad matrix scanner: drives columns low in turn, samples the
// synchronised rows at the end of each dwell, classifies every full scan and
// hands the result to the debounce FSM that produces the PIO key word.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [4:0] key_code,
    output logic       key_event
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

    logic [3:0]     r_row_meta;
    logic [3:0]     r_row_s;
    logic [DW-1:0]  r_dwell;
    logic [1:0]     r_col;
    logic [3:0]     r_col_n;
    logic [11:0]    r_samples;
    logic           r_scan_stb;
    scan_res_t      r_scan_res;
    logic [3:0]     r_scan_code;

    logic           w_dwell_end;
    logic           w_scan_end;
    logic [15:0]    w_matrix;
    logic [4:0]     w_act_cnt;
    logic [3:0]     w_act_pos;
    scan_res_t      w_scan_res;
    logic [3:0]     w_scan_code;

    assign w_dwell_end = (r_dwell == DWELL_LAST);
    assign w_scan_end  = w_dwell_end && (r_col == 2'd3);

    // Two-flop synchroniser for the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
        end else begin
            r_row_meta <= row_n;
            r_row_s    <= r_row_meta;
        end
    end

    // Dwell and column counters; the column drive is registered so col_n never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dwell <= '0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
        end else if (w_dwell_end) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
            r_col_n <= col_drive(r_col + 2'd1);
        end else begin
            r_dwell <= r_dwell + DWELL_ONE;
        end
    end

    // Capture active rows for columns 0..2; column 3 is taken live at scan end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samples <= 12'd0;
        end else if (w_dwell_end) begin
            case (r_col)
                2'd0:    r_samples[3:0]  <= ~r_row_s;
                2'd1:    r_samples[7:4]  <= ~r_row_s;
                2'd2:    r_samples[11:8] <= ~r_row_s;
                default: r_samples       <= r_samples;
            endcase
        end
    end

    // Bit index in the matrix is col*4 + row.
    assign w_matrix = {~r_row_s, r_samples};

    // Count active crossings and remember where the (last) one sits.
    always_comb begin
        w_act_cnt = 5'd0;
        w_act_pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_matrix[i]) begin
                w_act_cnt = w_act_cnt + 5'd1;
                w_act_pos = 4'(i);
            end
        end
    end

    // Classify the scan; code is {row, col} from the single active crossing.
    always_comb begin
        w_scan_res  = SCAN_NONE;
        w_scan_code = {w_act_pos[1:0], w_act_pos[3:2]};
        if (w_act_cnt == 5'd1) begin
            w_scan_res = SCAN_KEY;
        end else if (w_act_cnt != 5'd0) begin
            w_scan_res = SCAN_MULTI;
        end
    end

    // One strobe per full scan carrying its classification to the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_stb  <= 1'b0;
            r_scan_res  <= SCAN_NONE;
            r_scan_code <= 4'd0;
        end else begin
            r_scan_stb <= w_scan_end;
            if (w_scan_end) begin
                r_scan_res  <= w_scan_res;
                r_scan_code <= w_scan_code;
            end
        end
    end

    keypad_debounce_fsm #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .i_scan_stb (r_scan_stb),
        .i_scan_res (r_scan_res),
        .i_scan_code(r_scan_code),
        .o_key_code (key_code),
        .o_key_event(key_event)
    );

    assign col_n = r_col_n;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a virtual keypad answers the column drive,
// a scan-level reference model predicts key word changes into a queue, and a
// monitor compares every observed change against that queue.
module tb_keypad_matrix_scanner;
    import keypad_pkg::*;

    localparam int SD       = 4;
    localparam int DB       = 2;
    localparam int SCAN_CYC = 4 * SD;
    localparam int TIMEOUT  = 3 * SCAN_CYC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [4:0] key_code;
    logic       key_event;

    // Pressed keys; bit k set means the key whose code is k is down.
    logic [15:0] pressed = 16'd0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Expected observations: {event, key word} plus the cycle it was predicted.
    logic [5:0] exp_q[$];
    int         exp_t[$];

    // Model state: what is reported and the run length of identical scan results.
    logic       m_rep_valid = 1'b0;
    int         m_run = 0;
    int         m_last_kind = -1;
    int         m_last_code = -1;

    keypad_matrix_scanner #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_code (key_code),
        .key_event(key_event)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] word_of(input int code);
        logic [4:0] w;
        w = 5'd0;
        w[KEY_VALID_BIT] = 1'b1;
        w[3:0] = 4'(code);
        return w;
    endfunction

    // Scan-level rule: a key is reported after DB identical single-key scans
    // while nothing is reported; it is cleared after DB empty scans.
    task automatic model_scan(input logic [15:0] keys);
        int kind;
        int code;
        code = -1;
        for (int i = 0; i < 16; i++) if (keys[i]) code = i;
        kind = ($countones(keys) == 0) ? 0 : ($countones(keys) == 1) ? 1 : 2;
        if (kind == m_last_kind && (kind != 1 || code == m_last_code)) m_run++;
        else m_run = 1;
        m_last_kind = kind;
        m_last_code = code;
        if (!m_rep_valid && kind == 1 && m_run == DB) begin
            m_rep_valid = 1'b1;
            exp_q.push_back({1'b1, word_of(code)});
            exp_t.push_back(cyc);
        end else if (m_rep_valid && kind == 0 && m_run == DB) begin
            m_rep_valid = 1'b0;
            exp_q.push_back(6'd0);
            exp_t.push_back(cyc);
        end
    endtask

    // Present one full scan worth of key state; returns #1 after the scan-end edge.
    task automatic scan(input logic [15:0] keys);
        pressed = keys;
        model_scan(keys);
        repeat (SCAN_CYC) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] k(input logic [3:0] code);
        return 16'd1 << code;
    endfunction

    // Monitor: every event pulse or key word change must match the next prediction.
    logic [4:0] prev_code = 5'd0;
    always @(negedge clk) begin
        logic [5:0] e;
        if (key_event === 1'b1 || key_code !== prev_code) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {26'd0, key_event, key_code}, 32'h3F);
            end else begin
                e = exp_q.pop_front();
                void'(exp_t.pop_front());
                chk("scoreboard", {26'd0, key_event, key_code}, {26'd0, e});
            end
        end
        prev_code = key_code;
        if (exp_t.size() > 0 && (cyc - exp_t[0]) > TIMEOUT) begin
            e = exp_q.pop_front();
            void'(exp_t.pop_front());
            chk("output_timeout", {26'd0, key_event, key_code}, {26'd0, e});
        end
    end

    initial begin
        logic [15:0] keys;
        logic [3:0]  ka;
        logic [3:0]  kb;
        int          run;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_col_n", {28'd0, col_n}, 32'hE);
        chk("reset_key_code", {27'd0, key_code}, 32'd0);
        chk("reset_key_event", {31'd0, key_event}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle scan: column rotation every SD cycles.
        pressed = 16'd0;
        model_scan(16'd0);
        for (int n = 1; n <= SCAN_CYC; n++) begin
            @(posedge clk);
            #1;
            chk("idle_col_n", {28'd0, col_n}, {28'd0, ~(4'b0001 << ((n / SD) % 4))});
        end
        scan(16'd0);

        // Clean press of key 6 (row 1, column 2) held for several scans.
        for (int i = 0; i < 6; i++) scan(k(KEY_6));
        chk("press_code", {27'd0, key_code}, 32'h16);

        // Release, then a single empty scan glitch while pressed again.
        scan(16'd0);
        scan(16'd0);
        repeat (3) @(posedge clk);
        chk("release_code", {27'd0, key_code}, 32'd0);
        for (int i = 0; i < 3; i++) scan(k(KEY_HASH));
        scan(16'd0);
        scan(k(KEY_HASH));
        scan(k(KEY_HASH));
        chk("glitch_hold", {27'd0, key_code}, {27'd0, word_of(KEY_HASH)});
        scan(16'd0);
        scan(16'd0);

        // Bounce: toggle every scan, then settle.
        for (int i = 0; i < 5; i++) scan((i % 2 == 0) ? k(KEY_0) : 16'd0);
        for (int i = 0; i < 3; i++) scan(k(KEY_0));
        scan(16'd0);
        scan(16'd0);

        // Rollover: 5, then 5+9, then 9 alone; code stays 5 until a full release.
        for (int i = 0; i < 3; i++) scan(k(KEY_5));
        for (int i = 0; i < 3; i++) scan(k(KEY_5) | k(KEY_9));
        for (int i = 0; i < 3; i++) scan(k(KEY_9));
        chk("rollover_code", {27'd0, key_code}, {27'd0, word_of(KEY_5)});
        scan(16'd0);
        scan(16'd0);
        for (int i = 0; i < 3; i++) scan(k(KEY_9));
        chk("new_press_code", {27'd0, key_code}, {27'd0, word_of(KEY_9)});

        // Async reset while held; the key must requalify afterwards.
        pressed = k(KEY_9);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        if (m_rep_valid) begin
            exp_q.push_back(6'd0);
            exp_t.push_back(cyc);
        end
        m_rep_valid = 1'b0;
        m_run = 0;
        m_last_kind = -1;
        m_last_code = -1;
        #1;
        chk("mid_reset_col_n", {28'd0, col_n}, 32'hE);
        chk("mid_reset_code", {27'd0, key_code}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        scan(k(KEY_9));
        chk("requalify_wait", {27'd0, key_code}, 32'd0);
        scan(k(KEY_9));
        scan(k(KEY_9));
        chk("requalify_code", {27'd0, key_code}, {27'd0, word_of(KEY_9)});
        scan(16'd0);
        scan(16'd0);

        // Randomised runs of none / single / multi key states.
        for (int i = 0; i < 120; i++) begin
            ka = 4'($urandom_range(0, 15));
            kb = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2: keys = 16'd0;
                8, 9:    keys = k(ka) | k(kb);
                default: keys = k((i % 3 == 0) ? KEY_STAR : (i % 3 == 1) ? KEY_D : ka);
            endcase
            run = $urandom_range(1, 4);
            for (int j = 0; j < run; j++) scan(keys);
        end
        scan(16'd0);
        scan(16'd0);

        repeat (TIMEOUT + 8) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
